axi_stream_packetizer: RTL and testbench
========================================

Name: axi_stream_packetizer

Overview:
- Sits directly downstream of the 3-input stream combiner and directly upstream of the DMA/AXI writer.
- Buffers the combined 32-bit sample stream in a FIFO.
- Emits fixed-length packets with its own tlast, so the DMA receives one tlast every PACKET_LENGTH beats. Input tlast is ignored.
- Partial packets are flushed on an idle timeout or on an explicit flush request, so no samples are stranded.

Parameters:
- DATA_WIDTH, 32, width of tdata on both streams.
- DEST_WIDTH, 8, width of dest; passed through per beat.
- USER_WIDTH, 8, width of user; passed through per beat.
- FIFO_DEPTH, 2048, entries; power of 2; must be >= PACKET_LENGTH (elaboration error otherwise).
- PACKET_LENGTH, 1024, beats per full packet; >= 1.
- TIMEOUT_CYCLES, 4096, idle cycles before a partial packet is flushed; 0 disables the timeout.

Ports:
- clock  input  1  single clock for everything.
- reset  input  1  asynchronous, active-high.
- flush  input  1  single-cycle pulse; request a flush of the current partial packet.
- stream_in  axi_stream.slave  DATA_WIDTH/DEST_WIDTH/USER_WIDTH  from the combiner (data, dest, user, valid, ready; tlast ignored).
- stream_out  axi_stream.master  DATA_WIDTH/DEST_WIDTH/USER_WIDTH  to the DMA (data, dest, user, valid, ready, tlast).
- occupancy  output  $clog2(FIFO_DEPTH)+1  current FIFO entry count.

Behaviour:
- Clock and reset: one clock, `clock`. Reset is asynchronous and active-high, on port `reset`.
- Reset values:
  - state IDLE; FIFO pointers, occupancy, beat counter, flush length, timeout counter and flush_pending all 0.
  - stream_out.valid 0, stream_out.tlast 0, stream_in.ready 0 while reset is high.
- Reset asserted mid-packet: buffered data is discarded. No tlast is generated for the truncated packet.
- Write side:
  - stream_in.ready = (occupancy < FIFO_DEPTH), decoded from registered occupancy.
  - A write is never accepted at full, even if a read happens in the same cycle.
  - A beat is written on valid & ready and stores {data, dest, user}.
- Occupancy: +1 on write only, -1 on read only, unchanged on a simultaneous write and read.
- FIFO is first-word-fall-through: stream_out.data/dest/user always reflect the head entry.
- State machine: IDLE, SEND, FLUSH.
  - IDLE -> SEND when occupancy >= PACKET_LENGTH. SEND has priority over any flush condition in the same cycle.
  - IDLE -> FLUSH when occupancy is in 1..PACKET_LENGTH-1 and either flush_pending is set or the timeout has expired. flush_len is latched to occupancy on entry.
  - SEND -> IDLE on the handshake of beat PACKET_LENGTH-1.
  - FLUSH -> IDLE on the handshake of beat flush_len-1.
  - Beats written during FLUSH are not part of the flushed packet.
- Output:
  - stream_out.valid = (state != IDLE); the FIFO is guaranteed non-empty in those states.
  - The beat counter advances on valid & ready and is cleared on return to IDLE.
  - stream_out.tlast is high only on the final beat of SEND or FLUSH, is combinational with the counter, and holds while ready is low.
  - valid and data are held stable while ready is low (AXI-stream rule).
- Latency: the beat that makes occupancy reach PACKET_LENGTH is accepted at edge k. The state is SEND after edge k+1, and the first output beat is valid in the cycle after edge k+1.
- Timeout counter:
  - Counts only in IDLE with occupancy in 1..PACKET_LENGTH-1 and no input handshake this cycle.
  - Cleared by any input handshake or any state change.
  - Expires when count == TIMEOUT_CYCLES-1.
  - With TIMEOUT_CYCLES == 0 it never counts.
- flush input:
  - Sets flush_pending. flush_pending is cleared on entry to FLUSH.
  - A flush arriving during SEND or FLUSH is retained and serviced on the next IDLE if occupancy is in 1..PACKET_LENGTH-1.
  - In IDLE, if occupancy >= PACKET_LENGTH the SEND is taken and flush_pending is retained.
  - A flush with occupancy 0 in IDLE is dropped (flush_pending is cleared).
- Arithmetic: counters are sized $clog2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH, with no special case at the wrap boundary.

Test Plan:
- PACKET_LENGTH=8, FIFO_DEPTH=16, out ready=1; write 16 beats data 0..15 back-to-back -> two packets, data 0..7 then 8..15; tlast exactly on data 7 and 15; first out valid 2 cycles after beat 7 accepted.
- Write 3 beats (TIMEOUT_CYCLES=20), then idle -> FLUSH after 20 idle cycles; 3 beats out, tlast on the 3rd; occupancy returns to 0.
- flush pulse while 5 beats are buffered, out ready toggling 1/0 every cycle -> 5 beats in order, tlast on the 5th, valid/data/tlast stable during ready=0.
- Out ready=0, write until full (16) -> stream_in.ready=0 at occupancy 16; release ready -> one packet of 8, then ready reasserts, no data lost or duplicated across the pointer wrap.
- flush pulse during SEND with 3 extra beats written mid-packet -> full 8-beat packet, then immediate 3-beat FLUSH packet with tlast on its 3rd beat.
- Assert reset mid-SEND after 4 beats -> valid/tlast/ready drop immediately, occupancy 0, state IDLE; after release the next 8 writes form a clean packet.

Source files
------------

// File: rtl/axi_stream_packetizer_if.sv
// AXI-stream style link used on both sides of the packetizer: data/dest/user payload,
// valid/ready handshake and tlast.
interface axi_stream_packetizer_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEST_WIDTH = 8,
    parameter int unsigned USER_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic [USER_WIDTH-1:0] user;
    logic                  valid;
    logic                  ready;
    logic                  tlast;

    modport master (output data, dest, user, valid, tlast, input ready);
    modport slave  (input data, dest, user, valid, tlast, output ready);
endinterface

// File: rtl/axi_stream_packetizer.sv
// Buffers the combined sample stream in a FWFT FIFO and re-emits it as fixed-length
// packets, flushing partial packets on idle timeout or an explicit flush request.
module axi_stream_packetizer #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned DEST_WIDTH     = 8,
    parameter int unsigned USER_WIDTH     = 8,
    parameter int unsigned FIFO_DEPTH     = 2048,
    parameter int unsigned PACKET_LENGTH  = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    axi_stream_packetizer_if.slave        stream_in,
    axi_stream_packetizer_if.master       stream_out,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    if ((FIFO_DEPTH < PACKET_LENGTH) || (PACKET_LENGTH < 1) ||
        ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_params
        $error("axi_stream_packetizer: FIFO_DEPTH must be a power of 2 and >= PACKET_LENGTH >= 1");
    end

    typedef enum logic [1:0] {IDLE, SEND, FLUSH} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [DEST_WIDTH-1:0] dest;
        logic [USER_WIDTH-1:0] user;
    } entry_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   occ_q, occ_d;
    logic [CW-1:0]   beat_q, beat_d;
    logic [CW-1:0]   flush_len_q, flush_len_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            pend_q, pend_d;
    entry_t          mem_q [FIFO_DEPTH];

    entry_t          wr_entry;
    entry_t          head;
    logic            in_ready;
    logic            out_valid;
    logic            wr_en;
    logic            rd_en;
    logic            last_beat;
    logic            partial;
    logic            tmo_expired;

    assign in_ready    = !reset && (occ_q < CW'(FIFO_DEPTH));
    assign wr_en       = stream_in.valid && in_ready;
    assign out_valid   = (state_q != IDLE);
    assign rd_en       = out_valid && stream_out.ready;
    assign partial     = (occ_q != '0) && (occ_q < CW'(PACKET_LENGTH));
    assign tmo_expired = (TIMEOUT_CYCLES != 0) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign last_beat   = (state_q == SEND)  ? (beat_q == CW'(PACKET_LENGTH - 1)) :
                         (state_q == FLUSH) ? (beat_q == flush_len_q - CW'(1))    : 1'b0;

    assign wr_entry = '{data: stream_in.data, dest: stream_in.dest, user: stream_in.user};
    assign head     = mem_q[rd_ptr_q];

    assign stream_in.ready  = in_ready;
    assign stream_out.valid = out_valid;
    assign stream_out.tlast = out_valid && last_beat;
    assign stream_out.data  = head.data;
    assign stream_out.dest  = head.dest;
    assign stream_out.user  = head.user;
    assign occupancy        = occ_q;

    // Payload storage carries no reset; pointers and occupancy define validity.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            beat_q      <= '0;
            flush_len_q <= '0;
            tmo_q       <= '0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            beat_q      <= beat_d;
            flush_len_q <= flush_len_d;
            tmo_q       <= tmo_d;
            pend_q      <= pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        beat_d      = beat_q;
        flush_len_d = flush_len_q;
        tmo_d       = tmo_q;
        pend_d      = pend_q || flush;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase

        // A full packet always wins; a pending flush waits until the next IDLE.
        case (state_q)
            IDLE: begin
                if (occ_q >= CW'(PACKET_LENGTH)) begin
                    state_d = SEND;
                end else if (partial && (pend_q || tmo_expired)) begin
                    state_d     = FLUSH;
                    flush_len_d = occ_q;
                    pend_d      = 1'b0;
                end else if (occ_q == '0) begin
                    pend_d = 1'b0;
                end
            end
            default: begin
                if (rd_en) begin
                    if (last_beat) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + CW'(1);
                    end
                end
            end
        endcase

        if ((TIMEOUT_CYCLES == 0) || wr_en || (state_d != state_q)) begin
            tmo_d = '0;
        end else if ((state_q == IDLE) && partial && !tmo_expired) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

endmodule

// File: tb/tb_axi_stream_packetizer.sv
// Directed bench for axi_stream_packetizer with PACKET_LENGTH=8, FIFO_DEPTH=16, TIMEOUT_CYCLES=20.
module tb_axi_stream_packetizer;

    localparam int unsigned DW    = 32;
    localparam int unsigned EW    = 8;
    localparam int unsigned UW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned PLEN  = 8;
    localparam int unsigned TMO   = 20;
    localparam int unsigned OW    = $clog2(DEPTH) + 1;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          flush = 1'b0;
    logic [OW-1:0] occ;

    axi_stream_packetizer_if #(.DATA_WIDTH(DW), .DEST_WIDTH(EW), .USER_WIDTH(UW)) s_in ();
    axi_stream_packetizer_if #(.DATA_WIDTH(DW), .DEST_WIDTH(EW), .USER_WIDTH(UW)) s_out ();

    axi_stream_packetizer #(
        .DATA_WIDTH(DW), .DEST_WIDTH(EW), .USER_WIDTH(UW),
        .FIFO_DEPTH(DEPTH), .PACKET_LENGTH(PLEN), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clk),
        .reset(rst),
        .flush(flush),
        .stream_in(s_in),
        .stream_out(s_out),
        .occupancy(occ)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            passed = 0;
    int            fails  = 0;
    logic          stall_q = 1'b0;
    logic [DW-1:0] hold_data;
    logic          hold_last;
    int            cyc, first_valid, wr_total, wr_done, flush_at, ready_mode;
    logic [DW-1:0] wr_base;

    function automatic logic [EW-1:0] dest_of(input logic [DW-1:0] d);
        return EW'(d[7:0] ^ 8'h5A);
    endfunction

    function automatic logic [UW-1:0] user_of(input logic [DW-1:0] d);
        return UW'(d[7:0] + 8'd3);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_packet(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.data = base + DW'(i);
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic start_phase(input logic [DW-1:0] base, input int n, input int rmode, input int fat);
        wr_base     = base;
        wr_total    = n;
        wr_done     = 0;
        cyc         = 0;
        first_valid = -1;
        ready_mode  = rmode;
        flush_at    = fat;
    endtask

    // Score the output beat (if any) of the current cycle and the hold rule during stalls.
    task automatic observe();
        if (stall_q) begin
            check("hold_valid", 64'(s_out.valid), 64'd1);
            check("hold_data",  64'(s_out.data),  64'(hold_data));
            check("hold_tlast", 64'(s_out.tlast), 64'(hold_last));
        end
        if (s_out.valid && s_out.ready) begin
            check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_data",  64'(s_out.data),  64'(e.data));
                check("out_dest",  64'(s_out.dest),  64'(dest_of(e.data)));
                check("out_user",  64'(s_out.user),  64'(user_of(e.data)));
                check("out_tlast", 64'(s_out.tlast), 64'(e.last));
            end
        end
        stall_q   = s_out.valid && !s_out.ready;
        hold_data = s_out.data;
        hold_last = s_out.tlast;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            logic in_hs;
            s_in.valid = (wr_done < wr_total);
            s_in.data  = wr_base + DW'(wr_done);
            s_in.dest  = dest_of(wr_base + DW'(wr_done));
            s_in.user  = user_of(wr_base + DW'(wr_done));
            s_in.tlast = ((cyc % 3) == 0);
            flush      = (cyc == flush_at);
            case (ready_mode)
                0:       s_out.ready = 1'b1;
                1:       s_out.ready = ((cyc % 2) == 0);
                default: s_out.ready = 1'b0;
            endcase
            #1;
            in_hs = s_in.valid && s_in.ready;
            if (s_out.valid && first_valid < 0) first_valid = cyc;
            observe();
            @(posedge clk);
            #1;
            if (in_hs) wr_done++;
            cyc++;
        end
        flush = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        s_in.valid  = 1'b0;
        s_in.data   = '0;
        s_in.dest   = '0;
        s_in.user   = '0;
        s_in.tlast  = 1'b0;
        s_out.ready = 1'b0;

        // Reset state
        #1;
        check("rst_out_valid", 64'(s_out.valid), 64'd0);
        check("rst_out_tlast", 64'(s_out.tlast), 64'd0);
        check("rst_in_ready",  64'(s_in.ready),  64'd0);
        check("rst_occ",       64'(occ),         64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(s_in.ready), 64'd1);

        // Two back-to-back full packets
        start_phase(32'h0, 16, 0, -1);
        push_packet(32'h0, 8);
        push_packet(32'h8, 8);
        run(40);
        check("p1_first_valid", 64'(first_valid), 64'(9));
        check("p1_occ_end",     64'(occ),         64'd0);
        check("p1_all_out",     64'(exp_q.size()), 64'd0);
        check("p1_idle_valid",  64'(s_out.valid), 64'd0);

        // Timeout flush of a 3-beat partial
        start_phase(32'h100, 3, 0, -1);
        push_packet(32'h100, 3);
        run(22);
        check("tmo_not_early", 64'(first_valid), 64'(-1));
        check("tmo_occ_held",  64'(occ),         64'd3);
        run(10);
        check("tmo_first_valid", 64'(first_valid), 64'(23));
        check("tmo_occ_end",     64'(occ),         64'd0);
        check("tmo_all_out",     64'(exp_q.size()), 64'd0);

        // Explicit flush of 5 beats with ready toggling
        start_phase(32'h200, 5, 1, 6);
        push_packet(32'h200, 5);
        run(30);
        check("fl_first_valid", 64'(first_valid), 64'(8));
        check("fl_occ_end",     64'(occ),         64'd0);
        check("fl_all_out",     64'(exp_q.size()), 64'd0);

        // Fill to full with output stalled, then drain across the pointer wrap
        start_phase(32'h300, 24, 2, -1);
        push_packet(32'h300, 8);
        push_packet(32'h308, 8);
        push_packet(32'h310, 8);
        run(18);
        check("full_in_ready",  64'(s_in.ready),  64'd0);
        check("full_occ",       64'(occ),         64'd16);
        check("full_out_valid", 64'(s_out.valid), 64'd1);
        check("full_head_data", 64'(s_out.data),  64'h300);
        check("full_tlast",     64'(s_out.tlast), 64'd0);
        check("full_wr_done",   64'(wr_done),     64'd16);
        ready_mode = 0;
        run(50);
        check("wrap_occ_end", 64'(occ),          64'd0);
        check("wrap_all_out", 64'(exp_q.size()), 64'd0);
        check("wrap_wr_done", 64'(wr_done),      64'd24);

        // Flush request during SEND with 3 extra beats
        start_phase(32'h400, 11, 0, 12);
        push_packet(32'h400, 8);
        push_packet(32'h408, 3);
        run(17);
        check("mid_idle_valid", 64'(s_out.valid), 64'd0);
        check("mid_occ",        64'(occ),         64'd3);
        run(1);
        check("mid_fl_valid", 64'(s_out.valid), 64'd1);
        check("mid_fl_data",  64'(s_out.data),  64'h408);
        check("mid_fl_tlast", 64'(s_out.tlast), 64'd0);
        run(12);
        check("mid_occ_end", 64'(occ),          64'd0);
        check("mid_all_out", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a SEND
        start_phase(32'h500, 8, 0, -1);
        push_packet(32'h500, 8);
        run(13);
        check("pre_rst_valid", 64'(s_out.valid), 64'd1);
        check("pre_rst_occ",   64'(occ),         64'd4);
        rst = 1'b1;
        #1;
        check("mrst_out_valid", 64'(s_out.valid), 64'd0);
        check("mrst_out_tlast", 64'(s_out.tlast), 64'd0);
        check("mrst_in_ready",  64'(s_in.ready),  64'd0);
        check("mrst_occ",       64'(occ),         64'd0);
        exp_q.delete();
        stall_q = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mrst_rel_ready", 64'(s_in.ready),  64'd1);
        check("mrst_rel_valid", 64'(s_out.valid), 64'd0);
        start_phase(32'h600, 8, 0, -1);
        push_packet(32'h600, 8);
        run(25);
        check("rec_first_valid", 64'(first_valid), 64'(9));
        check("rec_occ_end",     64'(occ),          64'd0);
        check("rec_all_out",     64'(exp_q.size()), 64'd0);

        if (passed + fails != checks) $display("note: check bookkeeping inconsistent");
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
